pixel_fetch_concat: RTL and testbench

Parametrised read-side front end for `accelerator_core`. It replaces the `data_req` + `pixel_concat` pair with one block that:
- issues sequential BRAM word reads with credit-based flow control;
- absorbs arbitrary read latency in a word FIFO;
- unpacks the byte stream into `NUM_CHANNEL`-wide pixels for `i_data`/`i_data_val`.

Pixels may straddle word boundaries. It adds start/done/abort control, which the old pair lacks.

---
 rtl/accel_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/pixel_fetch_concat.sv | 194 +++++++++++++++++++
 tb/tb_pixel_fetch_concat.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types and sizing helpers for the accelerator read-side front end.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int bpw(input int dataWidth, input int bitWidth);
    return dataWidth / bitWidth;
  endfunction

  function automatic int accCap(input int numChannel, input int bytesPerWord);
    return numChannel - 1 + bytesPerWord;
  endfunction

  // Bits needed to hold every value from 0 up to and including maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count and a
// synchronous clear that drops all stored entries.
module sync_fifo
  import accel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = cntWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             pushEn;
  logic             popEn;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign popEn   = pop_i && !empty_o;
  assign pushEn  = push_i && (!full || popEn);
  assign rdata_o = mem[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[wrPtr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) wrPtr_q <= wrPtr_q + AW'(1);
      if (popEn)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + CW'(pushEn) - CW'(popEn);
    end
  end

endmodule

// File: rtl/pixel_fetch_concat.sv
// Sequential BRAM word fetch with credit flow control, a word FIFO that
// absorbs read latency, and a byte-stream unpacker producing pixels.
module pixel_fetch_concat
  import accel_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ADDR_STEP   = 4,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_base_addr,
  input  logic [31:0]                      i_num_words,
  input  logic                             i_req,
  input  logic                             i_end,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  output logic                             o_mem_rden,
  input  logic [DATA_WIDTH-1:0]            i_mem_data,
  input  logic                             i_mem_val,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0] o_data,
  output logic                             o_data_val,
  output logic                             o_busy,
  output logic                             o_done
);
  localparam int BPW  = bpw(DATA_WIDTH, BIT_WIDTH);
  localparam int CAP  = accCap(NUM_CHANNEL, BPW);
  localparam int ACCW = CAP * BIT_WIDTH;
  localparam int PIXW = NUM_CHANNEL * BIT_WIDTH;
  localparam int ACW  = cntWidth(CAP);
  localparam int FCW  = cntWidth(FIFO_DEPTH);

  if ((DATA_WIDTH % BIT_WIDTH) != 0 || NUM_CHANNEL < 1 || NUM_CHANNEL > 16 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RD_LATENCY < 0) begin : gBadParams
    $error("pixel_fetch_concat: illegal parameter combination");
  end

  state_e                state_q, state_d;
  logic [31:0]           numWords_q, numWords_d;
  logic [31:0]           issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] nextAddr_q, nextAddr_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic                  memRden_q, memRden_d;
  logic [FCW-1:0]        outst_q, outst_d;
  logic [ACCW-1:0]       acc_q, acc_d;
  logic [ACW-1:0]        accCnt_q, accCnt_d;
  logic [PIXW-1:0]       data_q, data_d;
  logic                  dataVal_q, dataVal_d;
  logic                  done_q, done_d;

  logic                  fifoClr, fifoPush, fifoPop, fifoEmpty;
  logic [DATA_WIDTH-1:0] fifoRdata;
  logic [FCW-1:0]        fifoCount;
  logic                  fire, emit, ret;
  logic [ACCW-1:0]       shifted, lowMask;
  int                    rem;

  // Returns with nothing outstanding are stale (e.g. issued before a reset).
  assign ret = i_mem_val && (outst_q != '0);

  sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) uWordFifo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (fifoClr),
    .push_i (fifoPush),
    .wdata_i(i_mem_data),
    .pop_i  (fifoPop),
    .rdata_o(fifoRdata),
    .count_o(fifoCount),
    .empty_o(fifoEmpty)
  );

  always_comb begin
    state_d    = state_q;
    numWords_d = numWords_q;
    issued_d   = issued_q;
    nextAddr_d = nextAddr_q;
    memAddr_d  = memAddr_q;
    acc_d      = acc_q;
    accCnt_d   = accCnt_q;
    data_d     = data_q;
    dataVal_d  = 1'b0;
    done_d     = 1'b0;
    fifoClr    = 1'b0;
    fifoPush   = 1'b0;
    fifoPop    = 1'b0;
    fire       = 1'b0;
    emit       = 1'b0;
    shifted    = acc_q;
    lowMask    = '0;
    rem        = 0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = RUN;
          numWords_d = i_num_words;
          fire       = (i_num_words != 32'd0);
          issued_d   = fire ? 32'd1 : 32'd0;
          memAddr_d  = i_base_addr;
          nextAddr_d = i_base_addr + ADDR_WIDTH'(ADDR_STEP);
          accCnt_d   = '0;
        end
      end
      RUN: begin
        if (i_end) begin
          state_d  = FLUSH;
          fifoClr  = 1'b1;
          accCnt_d = '0;
        end else if (issued_q == numWords_q && outst_q == '0 && fifoEmpty &&
                     int'(accCnt_q) < NUM_CHANNEL) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          accCnt_d = '0;
        end else begin
          fire = (issued_q < numWords_q) &&
                 (32'(outst_q) + 32'(fifoCount) < 32'(FIFO_DEPTH));
          if (fire) begin
            issued_d   = issued_q + 32'd1;
            memAddr_d  = nextAddr_q;
            nextAddr_d = nextAddr_q + ADDR_WIDTH'(ADDR_STEP);
          end
          fifoPush = ret;
          // Oldest samples sit in the LSBs; a popped word lands just above
          // whatever survives this cycle's emit.
          emit    = (int'(accCnt_q) >= NUM_CHANNEL) && i_req;
          rem     = int'(accCnt_q) - (emit ? NUM_CHANNEL : 0);
          shifted = emit ? (acc_q >> PIXW) : acc_q;
          fifoPop = !fifoEmpty && (rem + BPW <= CAP);
          lowMask = ~({ACCW{1'b1}} << (rem * BIT_WIDTH));
          acc_d   = shifted & lowMask;
          if (fifoPop) begin
            acc_d = acc_d | (ACCW'(fifoRdata) << (rem * BIT_WIDTH));
          end
          accCnt_d = ACW'(rem + (fifoPop ? BPW : 0));
          if (emit) begin
            data_d    = acc_q[PIXW-1:0];
            dataVal_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (outst_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    memRden_d = fire;
    outst_d   = outst_q + FCW'(fire) - FCW'(ret);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      numWords_q <= '0;
      issued_q   <= '0;
      nextAddr_q <= '0;
      memAddr_q  <= '0;
      memRden_q  <= 1'b0;
      outst_q    <= '0;
      acc_q      <= '0;
      accCnt_q   <= '0;
      data_q     <= '0;
      dataVal_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      numWords_q <= numWords_d;
      issued_q   <= issued_d;
      nextAddr_q <= nextAddr_d;
      memAddr_q  <= memAddr_d;
      memRden_q  <= memRden_d;
      outst_q    <= outst_d;
      acc_q      <= acc_d;
      accCnt_q   <= accCnt_d;
      data_q     <= data_d;
      dataVal_q  <= dataVal_d;
      done_q     <= done_d;
    end
  end

  assign o_mem_addr = memAddr_q;
  assign o_mem_rden = memRden_q;
  assign o_data     = data_q;
  assign o_data_val = dataVal_q;
  assign o_done     = done_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_fetch_concat.sv
// Scoreboard bench for pixel_fetch_concat: directed runs with a latency-2
// memory model whose byte k of the word at address a is a[7:0]+k.
module tb_pixel_fetch_concat;
  localparam int BW    = 8;
  localparam int NC    = 3;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 8;

  logic            clk;
  logic            rst;
  logic            i_start;
  logic [AW-1:0]   i_base_addr;
  logic [31:0]     i_num_words;
  logic            i_req;
  logic            i_end;
  logic [AW-1:0]   o_mem_addr;
  logic            o_mem_rden;
  logic [DW-1:0]   i_mem_data;
  logic            i_mem_val;
  logic [BW*NC-1:0] o_data;
  logic            o_data_val;
  logic            o_busy;
  logic            o_done;

  pixel_fetch_concat #(
    .BIT_WIDTH(BW), .NUM_CHANNEL(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ADDR_STEP(4), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_words(i_num_words), .i_req(i_req), .i_end(i_end),
    .o_mem_addr(o_mem_addr), .o_mem_rden(o_mem_rden), .i_mem_data(i_mem_data),
    .i_mem_val(i_mem_val), .o_data(o_data), .o_data_val(o_data_val),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  typedef struct { logic [BW*NC-1:0] pix; int expCyc; } pixExp_t;
  typedef struct { int expCyc; logic [AW-1:0] addr; } addrExp_t;
  pixExp_t  pixQ[$];
  addrExp_t addrQ[$];
  int pixelCount = 0;
  int rdenCount = 0;
  int lastRdenCyc = -1;
  int doneCount = 0;

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / BW; k++) w[k*BW +: BW] = a[7:0] + 8'(k);
    return w;
  endfunction

  function automatic logic [BW*NC-1:0] expectedPixel(input int p);
    int b;
    b = 3 * p;
    return {8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  // Memory responder: a strobe seen in cycle T returns data in cycle T+LAT.
  logic          pv [LAT];
  logic [DW-1:0] pd [LAT];
  always @(negedge clk) begin
    i_mem_val  = pv[LAT-1];
    i_mem_data = pd[LAT-1];
    for (int s = LAT - 1; s > 0; s--) begin
      pv[s] = pv[s-1];
      pd[s] = pd[s-1];
    end
    pv[0] = o_mem_rden;
    pd[0] = memWord(o_mem_addr);
  end

  // Monitor: pops expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (addrQ.size() > 0 && addrQ[0].expCyc == cyc) begin
      addrExp_t a;
      a = addrQ.pop_front();
      checkOutput("rden strobe", o_mem_rden, 1);
      checkOutput("rden addr", o_mem_addr, a.addr);
    end
    if (o_mem_rden) begin
      rdenCount++;
      lastRdenCyc = cyc;
    end
    if (o_done) doneCount++;
    if (o_data_val) begin
      pixelCount++;
      if (pixQ.size() == 0) begin
        checkOutput("spurious pixel strobe", o_data_val, 0);
      end else begin
        pixExp_t e;
        e = pixQ.pop_front();
        checkOutput("pixel data", o_data, e.pix);
        if (e.expCyc >= 0) checkOutput("pixel cycle", cyc, e.expCyc);
      end
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [31:0] nWords);
    i_base_addr = base;
    i_num_words = nWords;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  task automatic pushPixel(input logic [BW*NC-1:0] pix, input int expCyc);
    pixExp_t e;
    e.pix = pix;
    e.expCyc = expCyc;
    pixQ.push_back(e);
  endtask

  task automatic pushAddr(input int expCyc, input logic [AW-1:0] addr);
    addrExp_t a;
    a.expCyc = expCyc;
    a.addr = addr;
    addrQ.push_back(a);
  endtask

  task automatic waitIdle(input int budget, output int idleCyc, output logic doneSeen);
    idleCyc = -1;
    doneSeen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!o_busy) begin
        idleCyc = cyc;
        doneSeen = o_done;
        break;
      end
    end
    if (idleCyc < 0) checkOutput("idle timeout", o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, idle, r0, p0, d0;
    logic doneSeen;
    for (int s = 0; s < LAT; s++) begin
      pv[s] = 1'b0;
      pd[s] = '0;
    end
    rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_num_words = '0;
    i_req = 1'b0; i_end = 1'b0; i_mem_val = 1'b0; i_mem_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", o_busy, 0);
    checkOutput("reset rden", o_mem_rden, 0);
    checkOutput("reset addr", o_mem_addr, 0);
    checkOutput("reset data_val", o_data_val, 0);
    checkOutput("reset data", o_data, 0);
    checkOutput("reset done", o_done, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic: 3 words from 0x100");
    i_req = 1'b1;
    t0 = cyc;
    d0 = doneCount;
    pushAddr(t0 + 1, 32'h100);
    pushAddr(t0 + 2, 32'h104);
    pushAddr(t0 + 3, 32'h108);
    pushPixel(24'h020100, t0 + 6);
    pushPixel(24'h050403, t0 + 7);
    pushPixel(24'h080706, t0 + 8);
    pushPixel(24'h0B0A09, t0 + 9);
    applyStimulus(32'h100, 32'd3);
    waitIdle(50, idle, doneSeen);
    checkOutput("basic done with idle", doneSeen, 1);
    checkOutput("basic idle cycle", idle, t0 + 10);
    @(negedge clk); #1;
    checkOutput("basic done count", doneCount - d0, 1);
    checkOutput("basic pixels left", pixQ.size(), 0);
    checkOutput("basic busy after", o_busy, 0);

    $display("[TB] zero length");
    r0 = rdenCount;
    t0 = cyc;
    applyStimulus(32'h100, 32'd0);
    checkOutput("zero busy T1", o_busy, 1);
    waitIdle(10, idle, doneSeen);
    checkOutput("zero idle cycle", idle, t0 + 2);
    checkOutput("zero done with idle", doneSeen, 1);
    @(negedge clk); #1;
    checkOutput("zero rden count", rdenCount - r0, 0);

    $display("[TB] backpressure: 40 words, consumer stalled 30 cycles");
    i_req = 1'b0;
    r0 = rdenCount;
    p0 = pixelCount;
    for (int p = 0; p < 53; p++) pushPixel(expectedPixel(p), -1);
    t0 = cyc;
    applyStimulus(32'h100, 32'd40);
    repeat (29) @(negedge clk);
    #1;
    checkOutput("bp rden during stall", rdenCount - r0, 9);
    checkOutput("bp last rden cycle", lastRdenCyc, t0 + 9);
    checkOutput("bp no pixel during stall", pixelCount - p0, 0);
    i_req = 1'b1;
    waitIdle(400, idle, doneSeen);
    checkOutput("bp done with idle", doneSeen, 1);
    @(negedge clk); #1;
    checkOutput("bp pixel count", pixelCount - p0, 53);
    checkOutput("bp pixels left", pixQ.size(), 0);
    checkOutput("bp rden total", rdenCount - r0, 40);

    $display("[TB] abort at T5 of a 40-word run");
    r0 = rdenCount;
    p0 = pixelCount;
    d0 = doneCount;
    t0 = cyc;
    applyStimulus(32'h100, 32'd40);
    repeat (4) @(negedge clk);
    i_end = 1'b1;
    @(negedge clk);
    i_end = 1'b0;
    checkOutput("abort busy in flush", o_busy, 1);
    waitIdle(50, idle, doneSeen);
    checkOutput("abort idle cycle", idle, t0 + 9);
    checkOutput("abort no done at idle", doneSeen, 0);
    @(negedge clk); #1;
    checkOutput("abort rden total", rdenCount - r0, 5);
    checkOutput("abort last rden cycle", lastRdenCyc, t0 + 5);
    checkOutput("abort pixel count", pixelCount - p0, 0);
    checkOutput("abort done count", doneCount - d0, 0);

    $display("[TB] residual: 2 words after abort");
    t0 = cyc;
    pushPixel(24'h020100, t0 + 6);
    pushPixel(24'h050403, t0 + 7);
    applyStimulus(32'h100, 32'd2);
    waitIdle(50, idle, doneSeen);
    checkOutput("residual idle cycle", idle, t0 + 8);
    checkOutput("residual done with idle", doneSeen, 1);
    @(negedge clk); #1;
    checkOutput("residual pixels left", pixQ.size(), 0);

    $display("[TB] reset at T4 with reads outstanding");
    p0 = pixelCount;
    applyStimulus(32'h100, 32'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-reset busy", o_busy, 0);
    checkOutput("mid-reset rden", o_mem_rden, 0);
    checkOutput("mid-reset addr", o_mem_addr, 0);
    checkOutput("mid-reset data_val", o_data_val, 0);
    checkOutput("mid-reset data", o_data, 0);
    checkOutput("mid-reset done", o_done, 0);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("mid-reset stale pixels", pixelCount - p0, 0);
    t0 = cyc;
    pushPixel(24'h020100, t0 + 6);
    applyStimulus(32'h100, 32'd1);
    waitIdle(50, idle, doneSeen);
    checkOutput("restart idle cycle", idle, t0 + 7);
    checkOutput("restart done with idle", doneSeen, 1);
    @(negedge clk); #1;
    checkOutput("restart pixels left", pixQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
